bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Iterative double-dabble converter: turns a binary word into packed BCD digits over WIDTH clock cycles. Sits directly upstream of the seven-segment decoder and replaces the combinational divide/modulo path. Each 4-bit digit of bcd_out feeds one decoder digit input. Uses a start/busy/done handshake so display logic can sample any pipeline value (PC, register, counter) without a wide divider.

Parameters:
WIDTH, 32, width of binary input
DIGITS, 10, number of BCD digits produced (10 covers full 32-bit range)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request conversion of bin_in; sampled only when busy=0
bin_in  input  WIDTH  binary value, captured on accepted start edge
busy  output  1  conversion in progress
done  output  1  one-cycle pulse: bcd_out/overflow just updated
bcd_out  output  4*DIGITS  packed BCD, digit 0 (units) in [3:0]
overflow  output  1  bin_in >= 10^DIGITS for the last result
blank_mask  output  DIGITS  leading-zero blank flags (see Optional Feature)

Behaviour:
- Reset: rst=1 at a rising edge → state IDLE; busy=0, done=0, bcd_out=0, overflow=0, blank_mask=0, internal shift/count registers cleared. Applies mid-conversion: conversion abandoned, no done pulse.
- States: IDLE, SHIFT.
- IDLE: start=1 at edge → capture bin_in into shift reg, clear BCD working reg and overflow accumulator, count=0, go SHIFT, busy=1 from next cycle. start=0 → stay.
- SHIFT, each edge: for every working digit >= 5 add 3 (all digits in parallel, same cycle), then shift {bcd_work, bin_shift} left 1; bit shifted out of top digit ORed into overflow accumulator; count++.
- On the edge performing iteration WIDTH (count==WIDTH-1): write final BCD to bcd_out, accumulator to overflow, compute blank_mask, assert done for exactly the following cycle, busy=0, return IDLE.
- Latency: start accepted at edge E → busy high cycles E+1..E+WIDTH, done high cycle after edge E+WIDTH. Throughput one conversion per WIDTH cycles.
- start while busy=1: ignored, bin_in not recaptured. start during the done cycle (IDLE): accepted.
- bcd_out/overflow hold last result between conversions; not modified during SHIFT.
- Overflow: bcd_out = bin_in mod 10^DIGITS, overflow=1 iff any nonzero bit shifted out of top digit. Default params never overflow.
- Counter width = clog2(WIDTH)+1; no wrap within a conversion.

Optional Feature:
Macro BCD_BLANK_EN.
- Defined: on completion blank_mask[i]=1 for i>=1 when digit i and all higher digits are zero; blank_mask[0] always 0 (value 0 shows single "0"). Registered alongside bcd_out, reset 0. Downstream forces blanked digits to all-segments-off.
- Undefined: blank_mask tied to all zeros; no extra logic.

Test Plan:
- rst, then start with bin_in=0 → done exactly 32 cycles after accept edge, bcd_out=40'h0, overflow=0.
- bin_in=32'd1234 → bcd_out=40'h00_0000_1234; with BCD_BLANK_EN blank_mask=10'b1111110000.
- bin_in=32'hFFFF_FFFF → bcd_out=40'h42_9496_7295, overflow=0, blank_mask=0; start held high with bin_in changed to 7 during busy → no recapture; second conversion accepted in done cycle yields 40'h7.
- Start 32'd99999, assert rst for one cycle at busy cycle 10 → busy=0, bcd_out=0, no done pulse; fresh start converts 99999 correctly (40'h00_0009_9999).
- Instance WIDTH=8, DIGITS=2, bin_in=8'd123 → done after 8 cycles, bcd_out=8'h23, overflow=1; bin_in=8'd99 → 8'h99, overflow=0.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary to packed BCD converter.
// Optional leading-zero blanking enabled with BCD_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  shreg, shreg_nx;
  logic [BW-1:0]     work, work_nx;
  logic [BW-1:0]     adj;
  logic              ovf_acc, ovf_acc_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [BW-1:0]     bcd_nx;
  logic              ovf_nx;
  logic              done_nx;
  logic              last;

  assign busy = (state == SHIFT);
  assign last = (cnt == CW'(WIDTH - 1));

  // Add 3 to every working digit >= 5 before the shift
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  // Next-state and datapath updates for accept, shift and finish
  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    work_nx    = work;
    ovf_acc_nx = ovf_acc;
    cnt_nx     = cnt;
    bcd_nx     = bcd_out;
    ovf_nx     = overflow;
    done_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          shreg_nx   = bin_in;
          work_nx    = '0;
          ovf_acc_nx = 1'b0;
          cnt_nx     = '0;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        work_nx    = {adj[BW-2:0], shreg[WIDTH-1]};
        shreg_nx   = shreg << 1;
        ovf_acc_nx = ovf_acc | adj[BW-1];
        cnt_nx     = cnt + 1'b1;
        if (last) begin
          bcd_nx   = work_nx;
          ovf_nx   = ovf_acc_nx;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      work     <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      work     <= work_nx;
      ovf_acc  <= ovf_acc_nx;
      cnt      <= cnt_nx;
      bcd_out  <= bcd_nx;
      overflow <= ovf_nx;
      done     <= done_nx;
    end
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nx;

  // Digit i (i >= 1) blanks when it and every higher digit are zero
  function automatic logic [DIGITS-1:0] blank_of(
    input logic [BW-1:0] b
  );
    logic z;
    blank_of = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z & (b[4*i +: 4] == 4'd0);
      blank_of[i] = z;
    end
  endfunction

  // Blank flags follow the final result of each conversion
  always_comb begin
    blank_nx = blank_mask;
    if (done_nx)
      blank_nx = blank_of(work_nx);
  end

  // Blank mask register, updated alongside bcd_out
  always_ff @(posedge clk) begin
    if (rst)
      blank_mask <= '0;
    else
      blank_mask <= blank_nx;
  end
`else
  assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: default 32/10 instance
// plus a 8/2 instance exercising the overflow path.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_a, busy_a, done_a, ovf_a;
  logic [31:0] bin_a;
  logic [39:0] bcd_a;
  logic [9:0]  blank_a;

  logic        start_b, busy_b, done_b, ovf_b;
  logic [7:0]  bin_b;
  logic [7:0]  bcd_b;
  logic [1:0]  blank_b;

  int passed = 0;
  int total  = 0;
  longint cyc = 0;
  int done_cnt_a = 0;

  typedef struct {
    logic [63:0] bcd;
    logic        ovf;
    logic [9:0]  blank;
    longint      acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  bin_to_bcd_seq dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a),
    .overflow(ovf_a), .blank_mask(blank_a)
  );

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b),
    .overflow(ovf_b), .blank_mask(blank_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, got, want);
  endtask

  // Decimal reference: digits by repeated division
  function automatic exp_t model(input longint unsigned v,
                                 input int digits, input longint acc);
    exp_t e;
    longint unsigned p, r, d;
    int hi;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    e.ovf = (v >= p);
    r = v % p;
    e.bcd = '0;
    e.blank = '0;
    e.acc = acc;
    hi = 0;
    for (int i = 0; i < digits; i++) begin
      d = r % 10;
      r = r / 10;
      e.bcd = e.bcd | (d << (4 * i));
      if (d != 0) hi = i;
    end
`ifdef BCD_BLANK_EN
    for (int i = 1; i < digits; i++)
      if (i > hi) e.blank[i] = 1'b1;
`endif
    return e;
  endfunction

  // Monitor for the 32-bit instance
  always @(negedge clk) begin
    if (done_a) begin
      done_cnt_a++;
      if (qa.size() == 0) begin
        check("a_unexpected_done", 64'd1, 64'd0);
      end else begin
        ea = qa.pop_front();
        check("a_bcd", 64'(bcd_a), ea.bcd);
        check("a_ovf", 64'(ovf_a), 64'(ea.ovf));
        check("a_blank", 64'(blank_a), 64'(ea.blank));
        check("a_latency", 64'(cyc - ea.acc), 64'd32);
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (done_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_done", 64'd1, 64'd0);
      end else begin
        eb = qb.pop_front();
        check("b_bcd", 64'(bcd_b), eb.bcd);
        check("b_ovf", 64'(ovf_b), 64'(eb.ovf));
        check("b_blank", 64'(blank_b), 64'(eb.blank));
        check("b_latency", 64'(cyc - eb.acc), 64'd8);
      end
    end
  end

  task automatic go_a(input logic [31:0] v);
    int k;
    k = 0;
    @(negedge clk);
    while (busy_a) begin
      @(negedge clk);
      k++;
      if (k > 100) begin
        check("a_idle_timeout", 64'd1, 64'd0);
        return;
      end
    end
    start_a = 1'b1;
    bin_a = v;
    @(posedge clk);
    #1;
    qa.push_back(model(longint'(v), 10, cyc));
    start_a = 1'b0;
  endtask

  task automatic go_b(input logic [7:0] v);
    int k;
    k = 0;
    @(negedge clk);
    while (busy_b) begin
      @(negedge clk);
      k++;
      if (k > 100) begin
        check("b_idle_timeout", 64'd1, 64'd0);
        return;
      end
    end
    start_b = 1'b1;
    bin_b = v;
    @(posedge clk);
    #1;
    qb.push_back(model(longint'(v), 2, cyc));
    start_b = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    @(negedge clk);
    while (qa.size() != 0 || qb.size() != 0 || busy_a || busy_b) begin
      @(negedge clk);
      k++;
      if (k > 400) begin
        check("drain_timeout", 64'd1, 64'd0);
        qa.delete();
        qb.delete();
        return;
      end
    end
  endtask

  initial begin
    int k, seen;
    logic [31:0] v;
    start_a = 1'b0;
    bin_a = '0;
    start_b = 1'b0;
    bin_b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_bcd", 64'(bcd_a), 64'd0);
    check("rst_ovf", 64'(ovf_a), 64'd0);
    check("rst_blank", 64'(blank_a), 64'd0);
    check("rst_b_bcd", 64'(bcd_b), 64'd0);

    go_a(32'd0);
    go_a(32'd1234);
    drain();

    // start held high; bin_in changes while busy, then re-accepted
    @(negedge clk);
    start_a = 1'b1;
    bin_a = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    qa.push_back(model(64'h0000_0000_FFFF_FFFF, 10, cyc));
    bin_a = 32'd7;
    k = 0;
    @(negedge clk);
    while (!done_a && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("a_held_done_seen", 64'(done_a), 64'd1);
    @(posedge clk);
    #1;
    qa.push_back(model(64'd7, 10, cyc));
    start_a = 1'b0;
    @(negedge clk);
    check("a_busy_after_done_accept", 64'(busy_a), 64'd1);
    drain();

    foreach (v_tab[i]) go_a(v_tab[i]);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) v = $urandom;
      else v = $urandom_range(0, 99999);
      go_a(v);
    end
    drain();

    // abandon a conversion with reset
    go_a(32'd99999);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(qa.pop_back());
    seen = done_cnt_a;
    @(negedge clk);
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_bcd", 64'(bcd_a), 64'd0);
    check("midrst_done", 64'(done_a), 64'd0);
    repeat (40) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt_a - seen), 64'd0);
    go_a(32'd99999);
    drain();

    go_b(8'd123);
    go_b(8'd99);
    go_b(8'd100);
    go_b(8'd255);
    go_b(8'd0);
    for (int i = 0; i < 10; i++) go_b(8'($urandom_range(0, 255)));
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  logic [31:0] v_tab [8] = '{
    32'd9, 32'd10, 32'd99, 32'd100,
    32'd999_999_999, 32'd1_000_000_000,
    32'd4_294_967_294, 32'd1
  };

endmodule
